// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, opcode/funct
// constants, instruction classes and the select codes seen by the datapath.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Jump codes are shared with the next-PC unit and must stay in step with it.
    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JAL  = 2'b10,
        JMP_JR   = 2'b11
    } jump_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_OR    = 3'b010,
        ALU_LUI   = 3'b011,
        ALU_PASSA = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC4 = 2'b10
    } mem2reg_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps IR opcode/funct onto one class
// and flags anything the core does not implement.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = C_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_class = C_ADDU;
                    FN_SUBU: o_class = C_SUBU;
                    FN_JR:   o_class = C_JR;
                    default: o_class = C_ILLEGAL;
                endcase
            end
            OP_ORI:  o_class = C_ORI;
            OP_LUI:  o_class = C_LUI;
            OP_LW:   o_class = C_LW;
            OP_SW:   o_class = C_SW;
            OP_BEQ:  o_class = C_BEQ;
            OP_J:    o_class = C_J;
            OP_JAL:  o_class = C_JAL;
            default: o_class = C_ILLEGAL;
        endcase
    end

    assign o_legal = (o_class != C_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences IF/ID/EX/MEM/WB, handshakes with the
// shared memory port, drives next-PC controls and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_wr,
    output logic             o_ir_wr,
    output logic             o_pc_wr,
    output logic             o_branch,
    output logic [1:0]       o_jump,
    output logic             o_reg_wr,
    output logic [1:0]       o_reg_dst,
    output logic [1:0]       o_mem2reg,
    output logic             o_alu_src,
    output logic             o_ext_op,
    output logic [2:0]       o_alu_op,
    output logic [2:0]       o_state,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;
    iclass_t          w_class;
    logic             w_legal;
    // Branch resolution happens in the next-PC unit, so the flag is not needed here.
    logic             w_unused_zero;

    assign w_unused_zero = i_zero;

    mc_decode u_decode (
        .i_opcode (i_opcode),
        .i_funct  (i_funct),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IF;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID && !w_legal)
                r_illegal <= 1'b1;
            if (o_pc_wr)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:  w_next = i_mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (!w_legal)
                    w_next = S_TRAP;
                else if (w_class == C_J || w_class == C_JAL)
                    w_next = S_IF;
                else
                    w_next = S_EX;
            end
            S_EX: begin
                case (w_class)
                    C_LW, C_SW:  w_next = S_MEM;
                    C_BEQ, C_JR: w_next = S_IF;
                    default:     w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (i_mem_ready)
                    w_next = (w_class == C_SW) ? S_IF : S_WB;
            end
            S_WB:   w_next = S_IF;
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_IF;
        endcase
    end

    // Reset masks every output, including the debug state and the counter view.
    always_comb begin
        o_mem_req = 1'b0;
        o_mem_wr  = 1'b0;
        o_ir_wr   = 1'b0;
        o_pc_wr   = 1'b0;
        o_branch  = 1'b0;
        o_jump    = JMP_NONE;
        o_reg_wr  = 1'b0;
        o_reg_dst = DST_RT;
        o_mem2reg = M2R_ALU;
        o_alu_src = 1'b0;
        o_ext_op  = 1'b0;
        o_alu_op  = ALU_ADD;
        o_state   = '0;
        o_illegal = 1'b0;
        o_retired = '0;
        if (!i_rst) begin
            o_state   = r_state;
            o_illegal = r_illegal;
            o_retired = r_retired;
            case (r_state)
                S_IF: begin
                    o_mem_req = 1'b1;
                    o_ir_wr   = i_mem_ready;
                end
                S_ID: begin
                    if (w_class == C_J) begin
                        o_jump  = JMP_J;
                        o_pc_wr = 1'b1;
                    end else if (w_class == C_JAL) begin
                        o_jump    = JMP_JAL;
                        o_pc_wr   = 1'b1;
                        o_reg_wr  = 1'b1;
                        o_reg_dst = DST_RA;
                        o_mem2reg = M2R_PC4;
                    end
                end
                S_EX: begin
                    case (w_class)
                        C_SUBU: o_alu_op = ALU_SUB;
                        C_ORI: begin
                            o_alu_op  = ALU_OR;
                            o_alu_src = 1'b1;
                        end
                        C_LUI: begin
                            o_alu_op  = ALU_LUI;
                            o_alu_src = 1'b1;
                        end
                        C_LW, C_SW: begin
                            o_alu_src = 1'b1;
                            o_ext_op  = 1'b1;
                        end
                        C_BEQ: begin
                            o_alu_op = ALU_SUB;
                            o_ext_op = 1'b1;
                            o_branch = 1'b1;
                            o_pc_wr  = 1'b1;
                        end
                        C_JR: begin
                            o_alu_op = ALU_PASSA;
                            o_jump   = JMP_JR;
                            o_pc_wr  = 1'b1;
                        end
                        default: o_alu_op = ALU_ADD;
                    endcase
                end
                S_MEM: begin
                    o_mem_req = 1'b1;
                    o_alu_src = 1'b1;
                    o_ext_op  = 1'b1;
                    if (i_mem_ready && w_class == C_SW) begin
                        o_mem_wr = 1'b1;
                        o_pc_wr  = 1'b1;
                    end
                end
                S_WB: begin
                    o_reg_wr = 1'b1;
                    o_pc_wr  = 1'b1;
                    if (w_class == C_ADDU || w_class == C_SUBU)
                        o_reg_dst = DST_RD;
                    else if (w_class == C_LW)
                        o_mem2reg = M2R_MEM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: one vector per clock cycle, with
// hand-written sequences for trap, mid-handshake reset and counter wrap.
module tb_mc_ctrl;

    localparam logic [5:0] OPR  = 6'b000000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] LUI  = 6'b001111;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] ADDU = 6'b100001;
    localparam logic [5:0] SUBU = 6'b100011;
    localparam logic [5:0] JR   = 6'b001000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [2:0]  st;
        logic        req, mwr, irw, pcw, br;
        logic [1:0]  jmp;
        logic        rw;
        logic [1:0]  rd, m2r;
        logic        as, ext;
        logic [2:0]  aop;
        logic        ill;
        logic [31:0] ret;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic       zero, rdy;
        outs_t      exp;
        string      name;
    } vec_t;

    logic        i_clk, i_rst, i_zero, i_mem_ready;
    logic [5:0]  i_opcode, i_funct;
    logic        o_mem_req, o_mem_wr, o_ir_wr, o_pc_wr, o_branch, o_reg_wr;
    logic        o_alu_src, o_ext_op, o_illegal;
    logic [1:0]  o_jump, o_reg_dst, o_mem2reg;
    logic [2:0]  o_alu_op, o_state;
    logic [31:0] o_retired;

    int passCount = 0;
    int checkCount = 0;
    vec_t vecs[$];

    mc_ctrl #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_zero(i_zero), .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req),
        .o_mem_wr(o_mem_wr), .o_ir_wr(o_ir_wr), .o_pc_wr(o_pc_wr), .o_branch(o_branch),
        .o_jump(o_jump), .o_reg_wr(o_reg_wr), .o_reg_dst(o_reg_dst), .o_mem2reg(o_mem2reg),
        .o_alu_src(o_alu_src), .o_ext_op(o_ext_op), .o_alu_op(o_alu_op),
        .o_state(o_state), .o_illegal(o_illegal), .o_retired(o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic outs_t mko(input logic [2:0] st, input logic req, mwr, irw, pcw, br,
                                  input logic [1:0] jmp, input logic rw,
                                  input logic [1:0] rd, m2r, input logic as, ext,
                                  input logic [2:0] aop, input logic ill,
                                  input logic [31:0] ret);
        return {st, req, mwr, irw, pcw, br, jmp, rw, rd, m2r, as, ext, aop, ill, ret};
    endfunction

    function automatic vec_t mkv(input string name, input logic rst, input logic [5:0] op, fn,
                                 input logic zero, rdy, input outs_t exp);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.fn = fn;
        v.zero = zero; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        i_rst = v.rst; i_opcode = v.op; i_funct = v.fn;
        i_zero = v.zero; i_mem_ready = v.rdy;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        @(negedge i_clk);
        act = {o_state, o_mem_req, o_mem_wr, o_ir_wr, o_pc_wr, o_branch, o_jump, o_reg_wr,
               o_reg_dst, o_mem2reg, o_alu_src, o_ext_op, o_alu_op, o_illegal, o_retired};
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: outputs got %h, expected %h (retired got %0d, expected %0d)",
                     name, act, exp, act.ret, exp.ret);
        else
            passCount++;
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v.name, v.exp);
        @(posedge i_clk);
        #1;
    endtask

    // Instruction-level expectations shared by the short IF/ID preamble of most vectors.
    function automatic outs_t oIF(input logic irw, input logic [31:0] ret);
        return mko(0, 1, 0, irw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ret);
    endfunction

    function automatic outs_t oID(input logic [31:0] ret);
        return mko(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ret);
    endfunction

    initial begin
        vecs.push_back(mkv("rst",     1, J, 0, 0, 1, mko(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(mkv("j_if",    0, J, 0, 0, 1, oIF(1, 0)));
        vecs.push_back(mkv("j_id",    0, J, 0, 0, 1, mko(1,0,0,0,1,0,1,0,0,0,0,0,0,0,0)));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv("lw_ifwait", 0, LW, 0, 0, 0, oIF(0, 1)));
        vecs.push_back(mkv("lw_if",   0, LW, 0, 0, 1, oIF(1, 1)));
        vecs.push_back(mkv("lw_id",   0, LW, 0, 0, 1, oID(1)));
        vecs.push_back(mkv("lw_ex",   0, LW, 0, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,1,1,0,0,1)));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mkv("lw_memwait", 0, LW, 0, 0, 0, mko(3,1,0,0,0,0,0,0,0,0,1,1,0,0,1)));
        vecs.push_back(mkv("lw_mem",  0, LW, 0, 0, 1, mko(3,1,0,0,0,0,0,0,0,0,1,1,0,0,1)));
        vecs.push_back(mkv("lw_wb",   0, LW, 0, 0, 1, mko(4,0,0,0,1,0,0,1,0,1,0,0,0,0,1)));
        vecs.push_back(mkv("beq1_if", 0, BEQ, 0, 1, 1, oIF(1, 2)));
        vecs.push_back(mkv("beq1_id", 0, BEQ, 0, 1, 1, oID(2)));
        vecs.push_back(mkv("beq1_ex", 0, BEQ, 0, 1, 1, mko(2,0,0,0,1,1,0,0,0,0,0,1,1,0,2)));
        vecs.push_back(mkv("beq0_if", 0, BEQ, 0, 0, 1, oIF(1, 3)));
        vecs.push_back(mkv("beq0_id", 0, BEQ, 0, 0, 1, oID(3)));
        vecs.push_back(mkv("beq0_ex", 0, BEQ, 0, 0, 1, mko(2,0,0,0,1,1,0,0,0,0,0,1,1,0,3)));
        vecs.push_back(mkv("addu_if", 0, OPR, ADDU, 0, 1, oIF(1, 4)));
        vecs.push_back(mkv("addu_id", 0, OPR, ADDU, 0, 1, oID(4)));
        vecs.push_back(mkv("addu_ex", 0, OPR, ADDU, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,0,0,0,0,4)));
        vecs.push_back(mkv("addu_wb", 0, OPR, ADDU, 0, 1, mko(4,0,0,0,1,0,0,1,1,0,0,0,0,0,4)));
        vecs.push_back(mkv("subu_if", 0, OPR, SUBU, 0, 1, oIF(1, 5)));
        vecs.push_back(mkv("subu_id", 0, OPR, SUBU, 0, 1, oID(5)));
        vecs.push_back(mkv("subu_ex", 0, OPR, SUBU, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,0,0,1,0,5)));
        vecs.push_back(mkv("subu_wb", 0, OPR, SUBU, 0, 1, mko(4,0,0,0,1,0,0,1,1,0,0,0,0,0,5)));
        vecs.push_back(mkv("ori_if",  0, ORI, 0, 0, 1, oIF(1, 6)));
        vecs.push_back(mkv("ori_id",  0, ORI, 0, 0, 1, oID(6)));
        vecs.push_back(mkv("ori_ex",  0, ORI, 0, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,1,0,2,0,6)));
        vecs.push_back(mkv("ori_wb",  0, ORI, 0, 0, 1, mko(4,0,0,0,1,0,0,1,0,0,0,0,0,0,6)));
        vecs.push_back(mkv("lui_if",  0, LUI, 0, 0, 1, oIF(1, 7)));
        vecs.push_back(mkv("lui_id",  0, LUI, 0, 0, 1, oID(7)));
        vecs.push_back(mkv("lui_ex",  0, LUI, 0, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,1,0,3,0,7)));
        vecs.push_back(mkv("lui_wb",  0, LUI, 0, 0, 1, mko(4,0,0,0,1,0,0,1,0,0,0,0,0,0,7)));
        vecs.push_back(mkv("sw_if",   0, SW, 0, 0, 1, oIF(1, 8)));
        vecs.push_back(mkv("sw_id",   0, SW, 0, 0, 1, oID(8)));
        vecs.push_back(mkv("sw_ex",   0, SW, 0, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,1,1,0,0,8)));
        vecs.push_back(mkv("sw_mem",  0, SW, 0, 0, 1, mko(3,1,1,0,1,0,0,0,0,0,1,1,0,0,8)));
        vecs.push_back(mkv("jr_if",   0, OPR, JR, 0, 1, oIF(1, 9)));
        vecs.push_back(mkv("jr_id",   0, OPR, JR, 0, 1, oID(9)));
        vecs.push_back(mkv("jr_ex",   0, OPR, JR, 0, 1, mko(2,0,0,0,1,0,3,0,0,0,0,0,4,0,9)));
        vecs.push_back(mkv("jal_if",  0, JAL, 0, 0, 1, oIF(1, 10)));
        vecs.push_back(mkv("jal_id",  0, JAL, 0, 0, 1, mko(1,0,0,0,1,0,2,1,2,2,0,0,0,0,10)));
        vecs.push_back(mkv("bad_ifwait", 0, BAD, 0, 0, 0, oIF(0, 11)));

        foreach (vecs[i]) runVec(vecs[i]);

        // Unsupported opcode: sticky trap that ignores memory and zero until reset.
        runVec(mkv("bad_if", 0, BAD, 0, 0, 1, oIF(1, 11)));
        runVec(mkv("bad_id", 0, BAD, 0, 0, 1, oID(11)));
        for (int k = 0; k < 20; k++)
            runVec(mkv("trap_hold", 0, BAD, 0, k[0], k[1],
                       mko(7,0,0,0,0,0,0,0,0,0,0,0,0,1,11)));
        runVec(mkv("trap_rst",  1, BAD, 0, 0, 1, mko(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        runVec(mkv("trap_clr",  0, J, 0, 0, 0, oIF(0, 0)));

        // Unsupported funct on an R-type also traps.
        runVec(mkv("badfn_if", 0, OPR, 6'b100000, 0, 1, oIF(1, 0)));
        runVec(mkv("badfn_id", 0, OPR, 6'b100000, 0, 1, oID(0)));
        runVec(mkv("badfn_trap", 0, OPR, 6'b100000, 0, 1, mko(7,0,0,0,0,0,0,0,0,0,0,0,0,1,0)));
        runVec(mkv("badfn_rst", 1, OPR, 6'b100000, 0, 1, mko(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)));

        // Reset during the sw memory handshake must suppress the write and PC update.
        runVec(mkv("j2_if",    0, J, 0, 0, 1, oIF(1, 0)));
        runVec(mkv("j2_id",    0, J, 0, 0, 1, mko(1,0,0,0,1,0,1,0,0,0,0,0,0,0,0)));
        runVec(mkv("swr_if",   0, SW, 0, 0, 1, oIF(1, 1)));
        runVec(mkv("swr_id",   0, SW, 0, 0, 1, oID(1)));
        runVec(mkv("swr_ex",   0, SW, 0, 0, 1, mko(2,0,0,0,0,0,0,0,0,0,1,1,0,0,1)));
        runVec(mkv("swr_rst",  1, SW, 0, 0, 1, mko(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        runVec(mkv("swr_after", 0, SW, 0, 0, 0, oIF(0, 0)));

        // Counter wrap: preload all-ones while stalled in IF, then retire a jal.
        applyStimulus(mkv("wrap_pre", 0, JAL, 0, 0, 0, oIF(0, ONES)));
        force dut.r_retired = ONES;
        #1;
        release dut.r_retired;
        checkOutput("wrap_pre", oIF(0, ONES));
        @(posedge i_clk);
        #1;
        runVec(mkv("wrap_if",  0, JAL, 0, 0, 1, oIF(1, ONES)));
        runVec(mkv("wrap_id",  0, JAL, 0, 0, 1, mko(1,0,0,0,1,0,2,1,2,2,0,0,0,0,ONES)));
        runVec(mkv("wrap_done", 0, JAL, 0, 0, 0, oIF(0, 0)));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
